// File: rtl/spi_slave_tx.sv
// -----------------------------------------------------------------------------
// spi_slave_tx
//
// Responder-side transmit path of the SPI link. A word handed over by the
// local logic through newd/ready is shifted out on miso while the master
// clocks sclk with cs held low. The block runs entirely on clk; sclk and cs
// are oversampled through 2-flop synchronisers plus one history flop used
// for edge detection.
//
// Handshake: din is captured on any clk edge where newd and ready are both
// high. ready is high only while the FSM is in IDLE; newd is ignored in any
// other state.
//
// Build option:
//   SPI_SLAVE_TX_MSB_FIRST_EN  undefined (default): LSB first, shift right.
//                              defined: MSB first, shift left.
//
// Ports:
//   clk    in            system clock
//   rst    in            synchronous reset, active-high
//   newd   in            load strobe (qualified by ready)
//   din    in  [WIDTH]   word to transmit
//   sclk   in            SPI clock from master, asynchronous to clk
//   cs     in            SPI chip select from master, active-low, asynchronous
//   miso   out           registered serial data to master
//   ready  out           block can accept a new word (FSM in IDLE)
//   done   out           one-cycle pulse, all WIDTH bits sampled by master
//   abort  out           one-cycle pulse, cs released before the word ended
// -----------------------------------------------------------------------------
module spi_slave_tx #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             newd,
    input  logic [WIDTH-1:0] din,
    input  logic             sclk,
    input  logic             cs,
    output logic             miso,
    output logic             ready,
    output logic             done,
    output logic             abort
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SHIFT = 2'd2,
        ST_COMP  = 2'd3
    } state_e;

    // Synchroniser chains: bit 0 is the first stage, bit 1 the synchronised
    // value, bit 2 the history flop used for edge detection.
    logic [2:0] sclk_hist_q, sclk_hist_d;
    logic [2:0] cs_hist_q,   cs_hist_d;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hold_q,  hold_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             miso_q,  miso_d;
    logic             done_q,  done_d;
    logic             abort_q, abort_d;

    logic s_rise, s_fall, cs_fall, cs_rise;

    always_comb begin
        sclk_hist_d = {sclk_hist_q[1:0], sclk};
        cs_hist_d   = {cs_hist_q[1:0], cs};
    end

    assign s_rise  =  sclk_hist_q[1] & ~sclk_hist_q[2];
    assign s_fall  = ~sclk_hist_q[1] &  sclk_hist_q[2];
    assign cs_fall = ~cs_hist_q[1]   &  cs_hist_q[2];
    assign cs_rise =  cs_hist_q[1]   & ~cs_hist_q[2];

    // Next-state and datapath logic.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        miso_d  = miso_q;
        done_d  = 1'b0;
        abort_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Underrun: a cs-low period seen here is simply ignored.
                miso_d = 1'b0;
                if (newd) begin
                    hold_d  = din;
                    state_d = ST_ARMED;
                end
            end

            ST_ARMED: begin
                // Only a fresh high-to-low edge starts a frame; if cs was
                // already low when the word was loaded we wait it out.
                miso_d = 1'b0;
                if (cs_fall) begin
                    shift_d = hold_q;
`ifdef SPI_SLAVE_TX_MSB_FIRST_EN
                    miso_d  = hold_q[WIDTH-1];
`else
                    miso_d  = hold_q[0];
`endif
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                // The master samples on sclk rising; count that first so a
                // final sample coinciding with cs release still completes.
                if (s_rise && (cnt_q < CNT_FULL)) begin
                    cnt_d = cnt_q + 1'b1;
                end

                if (cnt_d == CNT_FULL) begin
                    miso_d  = 1'b0;
                    state_d = ST_COMP;
                end else if (cs_rise) begin
                    // cs release beats a coincident sclk fall.
                    abort_d = 1'b1;
                    miso_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (s_fall) begin
`ifdef SPI_SLAVE_TX_MSB_FIRST_EN
                    shift_d = {shift_q[WIDTH-2:0], 1'b0};
                    miso_d  = shift_q[WIDTH-2];
`else
                    shift_d = {1'b0, shift_q[WIDTH-1:1]};
                    miso_d  = shift_q[1];
`endif
                end
            end

            ST_COMP: begin
                done_d  = 1'b1;
                miso_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                miso_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_hist_q <= 3'b000;
            cs_hist_q   <= 3'b111;
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            shift_q     <= '0;
            cnt_q       <= '0;
            miso_q      <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            sclk_hist_q <= sclk_hist_d;
            cs_hist_q   <= cs_hist_d;
            state_q     <= state_d;
            hold_q      <= hold_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            miso_q      <= miso_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
        end
    end

    assign miso  = miso_q;
    assign ready = (state_q == ST_IDLE);
    assign done  = done_q;
    assign abort = abort_q;

endmodule

// File: tb/tb_spi_slave_tx.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_tx
//
// Directed bench for spi_slave_tx. A behavioural SPI master (mode 0, 11-cycle
// half-period) clocks frames and reassembles miso into rx_word. Every word
// that should complete is pushed into exp_q at load time; a monitor pops and
// compares against rx_word whenever done pulses.
// -----------------------------------------------------------------------------
module tb_spi_slave_tx;

    localparam int WIDTH = 12;
    localparam int HALF  = 11;

    logic             clk;
    logic             rst;
    logic             newd;
    logic [WIDTH-1:0] din;
    logic             sclk;
    logic             cs;
    logic             miso;
    logic             ready;
    logic             done;
    logic             abort;

    spi_slave_tx #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .newd  (newd),
        .din   (din),
        .sclk  (sclk),
        .cs    (cs),
        .miso  (miso),
        .ready (ready),
        .done  (done),
        .abort (abort)
    );

    // ---------------------------------------------------------------- clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------- bookkeeping
    int               cmp_cnt   = 0;
    int               err_cnt   = 0;
    int               done_cnt  = 0;
    int               abort_cnt = 0;
    int               bit_idx   = -1;
    logic [WIDTH-1:0] rx_word   = '0;
    logic             first_bit = 1'b0;
    logic [WIDTH-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (done === 1'b1) begin
                done_cnt++;
                check("done_has_expected_word", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    check("rx_word", rx_word, exp_q.pop_front());
                end
            end
            if (abort === 1'b1) begin
                abort_cnt++;
            end
        end
    end

    // --------------------------------------------------------- driver tasks
    task automatic half_period();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Loads w on the first cycle ready is seen high.
    task automatic load_word(input logic [WIDTH-1:0] w, input bit expect_tx);
        bit ok;
        wait_ready(ok);
        check("ready_wait_bound", ok, 1);
        if (ok) begin
            newd = 1'b1;
            din  = w;
            @(negedge clk);
            newd = 1'b0;
            check("ready_low_after_load", ready, 0);
            if (expect_tx) exp_q.push_back(w);
        end
    endtask

    // SPI master: nbits sample points, then cs released.
    task automatic spi_xfer(input int nbits, input bit underrun);
        rx_word = '0;
        cs = 1'b0;
        half_period();
        for (int i = 0; i < nbits; i++) begin
            bit_idx = i;
            if (i == 0) first_bit = miso;
            if (underrun) begin
                check("underrun_miso", miso, 0);
                check("underrun_ready", ready, 1);
            end
`ifdef SPI_SLAVE_TX_MSB_FIRST_EN
            rx_word[WIDTH-1-i] = miso;
`else
            rx_word[i] = miso;
`endif
            sclk = 1'b1;
            half_period();
            sclk = 1'b0;
            half_period();
        end
        cs = 1'b1;
        half_period();
        bit_idx = -1;
    endtask

    function automatic logic exp_first(input logic [WIDTH-1:0] w);
`ifdef SPI_SLAVE_TX_MSB_FIRST_EN
        return w[WIDTH-1];
`else
        return w[0];
`endif
    endfunction

    // ------------------------------------------------------------ watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        int d0;
        int a0;
        bit ok;

        rst  = 1'b1;
        newd = 1'b0;
        din  = '0;
        sclk = 1'b0;
        cs   = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_ready", ready, 1);
        check("reset_miso", miso, 0);
        check("reset_done", done, 0);
        check("reset_abort", abort, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_reset_ready", ready, 1);

        // Basic frame.
        d0 = done_cnt;
        a0 = abort_cnt;
        load_word(12'hA5C, 1'b1);
        spi_xfer(WIDTH, 1'b0);
        check("basic_first_bit", first_bit, exp_first(12'hA5C));
        check("basic_done_count", done_cnt - d0, 1);
        check("basic_abort_count", abort_cnt - a0, 0);
        check("basic_ready_back", ready, 1);
        check("basic_miso_idle", miso, 0);

        // Back-to-back: second word loaded as soon as ready returns, while
        // cs of the first frame is still low.
        d0 = done_cnt;
        load_word(12'h001, 1'b1);
        fork
            spi_xfer(WIDTH, 1'b0);
            load_word(12'hFFE, 1'b1);
        join
        spi_xfer(WIDTH, 1'b0);
        check("b2b_done_count", done_cnt - d0, 2);

        // Abort after 5 sample points.
        d0 = done_cnt;
        a0 = abort_cnt;
        load_word(12'h3C3, 1'b0);
        spi_xfer(5, 1'b0);
        check("abort_count", abort_cnt - a0, 1);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_miso", miso, 0);
        check("abort_ready", ready, 1);
        load_word(12'h0F0, 1'b1);
        spi_xfer(WIDTH, 1'b0);
        check("after_abort_done_count", done_cnt - d0, 1);

        // Underrun: frame with nothing loaded.
        d0 = done_cnt;
        a0 = abort_cnt;
        spi_xfer(WIDTH, 1'b1);
        check("underrun_no_done", done_cnt - d0, 0);
        check("underrun_no_abort", abort_cnt - a0, 0);

        // Reset during bit 7.
        d0 = done_cnt;
        a0 = abort_cnt;
        load_word(12'h555, 1'b0);
        fork
            spi_xfer(WIDTH, 1'b0);
            begin
                ok = 1'b0;
                for (int i = 0; i < 5000; i++) begin
                    @(negedge clk);
                    if (bit_idx == 6 && sclk === 1'b1) begin
                        ok = 1'b1;
                        break;
                    end
                end
                check("reset_point_reached", ok, 1);
                rst = 1'b1;
                @(negedge clk);
                check("midreset_miso", miso, 0);
                check("midreset_ready", ready, 1);
                check("midreset_done", done, 0);
                check("midreset_abort", abort, 0);
                rst = 1'b0;
            end
        join
        check("midreset_no_done", done_cnt - d0, 0);
        check("midreset_no_abort", abort_cnt - a0, 0);
        load_word(12'h555, 1'b1);
        spi_xfer(WIDTH, 1'b0);
        check("after_reset_done_count", done_cnt - d0, 1);

`ifdef SPI_SLAVE_TX_MSB_FIRST_EN
        load_word(12'h801, 1'b1);
        spi_xfer(WIDTH, 1'b0);
        check("msb_first_bit", first_bit, 1);
`endif

        repeat (20) @(negedge clk);
        check("no_pending_words", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
